// File: rtl/pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_buffer
// Brief    : Two-bank frame buffer; producer fills one bank while the consumer
//            reads the other, banks swap via w_done/r_done handshakes.
//            Define PINGPONG_CLEAR_EN to zero both banks after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_buffer #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_NUM   = 196,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [WORD_WIDTH-1:0] d,
  input  logic                  w_done,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [WORD_WIDTH-1:0] q,
  output logic                  r_valid,
  input  logic                  r_done,
  output logic [1:0]            level,
  output logic                  busy
);

  localparam int                  c_IDX_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
  localparam logic [ADDR_WIDTH:0] c_WORD_NUM = (ADDR_WIDTH + 1)'(WORD_NUM);

  logic                  r_wsel;
  logic                  r_rsel;
  logic [1:0]            r_full;
  logic                  r_we;
  logic                  r_wsel_d;
  logic [c_IDX_W-1:0]    r_wa;
  logic [WORD_WIDTH-1:0] r_d;
  logic [WORD_WIDTH-1:0] r_bank0 [WORD_NUM];
  logic [WORD_WIDTH-1:0] r_bank1 [WORD_NUM];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [c_IDX_W-1:0]    w_clr_addr;
  logic                  w_wa_ok;
  logic                  w_ra_ok;
  logic                  w_w_acc;
  logic                  w_r_acc;
  logic [c_IDX_W-1:0]    w_ra_idx;

  assign w_ready  = !r_full[r_wsel] && !w_busy;
  assign r_valid  = r_full[r_rsel];
  assign level    = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign busy     = w_busy;
  assign w_wa_ok  = ({1'b0, wa} < c_WORD_NUM);
  assign w_ra_ok  = ({1'b0, ra} < c_WORD_NUM);
  assign w_w_acc  = w_done && w_ready;
  assign w_r_acc  = r_done && r_valid;
  assign w_ra_idx = ra[c_IDX_W-1:0];

`ifdef PINGPONG_CLEAR_EN
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } clr_state_t;

  localparam logic [c_IDX_W-1:0] c_CLR_LAST = c_IDX_W'(WORD_NUM - 1);

  clr_state_t         r_state;
  clr_state_t         w_state_nxt;
  logic [c_IDX_W-1:0] r_clr_cnt;
  logic [c_IDX_W-1:0] w_clr_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_cnt == c_CLR_LAST) begin
          w_state_nxt   = S_IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_busy     = (r_state == S_CLEAR);
  assign w_clr_we   = w_busy;
  assign w_clr_addr = r_clr_cnt;
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  // w_done and r_done can never target the same bank, so both updates may land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
      r_full <= 2'b00;
      r_we   <= 1'b0;
    end else begin
      r_we <= we && w_ready && w_wa_ok;
      if (w_w_acc) begin
        r_full[r_wsel] <= 1'b1;
        r_wsel         <= !r_wsel;
      end
      if (w_r_acc) begin
        r_full[r_rsel] <= 1'b0;
        r_rsel         <= !r_rsel;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_wsel_d <= r_wsel;
    r_wa     <= wa[c_IDX_W-1:0];
    r_d      <= d;
  end

  // A write still in the pipeline when reset arrives is discarded, not committed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clr_we) begin
        r_bank0[w_clr_addr] <= '0;
        r_bank1[w_clr_addr] <= '0;
      end else if (r_we) begin
        if (r_wsel_d) begin
          r_bank1[r_wa] <= r_d;
        end else begin
          r_bank0[r_wa] <= r_d;
        end
      end
    end
  end

  always_comb begin
    q = '0;
    if (w_ra_ok) begin
      q = r_rsel ? r_bank1[w_ra_idx] : r_bank0[w_ra_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pingpong_buffer
// Brief    : Directed bench for pingpong_buffer with a frame-count reference
//            model; honours PINGPONG_CLEAR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pingpong_buffer;

  localparam int WN = 4;
`ifdef PINGPONG_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       we     = 1'b0;
  logic       w_done = 1'b0;
  logic       r_done = 1'b0;
  logic [7:0] wa     = 8'd0;
  logic [7:0] d      = 8'd0;
  logic [7:0] ra     = 8'd0;
  logic       w_ready;
  logic       r_valid;
  logic       busy;
  logic [7:0] q;
  logic [1:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pingpong_buffer #(
    .ADDR_WIDTH(8),
    .WORD_NUM  (WN),
    .WORD_WIDTH(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .wa     (wa),
    .d      (d),
    .w_done (w_done),
    .w_ready(w_ready),
    .ra     (ra),
    .q      (q),
    .r_valid(r_valid),
    .r_done (r_done),
    .level  (level),
    .busy   (busy)
  );

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_v(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%h required=0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames written/read counts decide bank roles and flags.
  int         fw = 0;
  int         fr = 0;
  int         busy_left = 0;
  bit         m_init = 1'b0;
  bit         pend = 1'b0;
  int         pb = 0;
  int         pa = 0;
  logic [7:0] pdat = 8'd0;
  logic [7:0] mm [2][WN];
  bit         kn [2][WN];

  always @(posedge clk) begin : model
    int lvl;
    bit rdy;
    bit vld;
    if (reset) begin
      fw        = 0;
      fr        = 0;
      pend      = 1'b0;
      busy_left = CLR ? WN : 0;
      m_init    = 1'b1;
    end else if (m_init) begin
      lvl = fw - fr;
      rdy = (lvl < 2) && (busy_left == 0);
      vld = (lvl > 0);
      if (pend) begin
        mm[pb][pa] = pdat;
        kn[pb][pa] = 1'b1;
      end
      if (busy_left > 0) begin
        for (int b = 0; b < 2; b++) begin
          mm[b][WN - busy_left] = 8'h00;
          kn[b][WN - busy_left] = 1'b1;
        end
        busy_left--;
      end
      pend = we && rdy && (int'(wa) < WN);
      pb   = fw % 2;
      pa   = int'(wa);
      pdat = d;
      if (w_done && rdy) fw++;
      if (r_done && vld) fr++;
    end
  end

  always @(negedge clk) begin : cmp
    int lvl;
    int rb;
    if (m_init) begin
      lvl = fw - fr;
      rb  = fr % 2;
      check_b("cyc_w_ready", w_ready, (lvl < 2) && (busy_left == 0));
      check_b("cyc_r_valid", r_valid, lvl > 0);
      check_v("cyc_level", {6'b0, level}, 8'(lvl));
      check_b("cyc_busy", busy, busy_left > 0);
      if (int'(ra) >= WN) check_v("cyc_q_oob", q, 8'h00);
      else if (kn[rb][ra[1:0]]) check_v("cyc_q", q, mm[rb][ra[1:0]]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [7:0] v);
    we = 1'b1; wa = a; d = v;
    tick();
    we = 1'b0;
  endtask

  task automatic pulse_w();
    w_done = 1'b1;
    tick();
    w_done = 1'b0;
  endtask

  task automatic pulse_r();
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
    ra = a;
    #1;
    check_v(name, q, exp);
  endtask

  task automatic count_busy(input int exp);
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_v("busy_cycles", 8'(n), 8'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_b("rst_r_valid", r_valid, 1'b0);
    check_v("rst_level", {6'b0, level}, 8'd0);
    check_b("rst_busy", busy, CLR);
    check_b("rst_w_ready", w_ready, !CLR);
    count_busy(CLR ? 4 : 0);
    check_b("idle_w_ready", w_ready, 1'b1);

    // Single frame into bank 0
    for (int i = 0; i < 4; i++) write_word(8'(i), 8'(8'h11 + i));
    pulse_w();
    check_b("t1_r_valid", r_valid, 1'b1);
    check_v("t1_level", {6'b0, level}, 8'd1);
    rd("t1_q0", 8'd0, 8'h11);
    rd("t1_q1", 8'd1, 8'h12);
    rd("t1_q2", 8'd2, 8'h13);
    rd("t1_q3", 8'd3, 8'h14);
    pulse_r();

    // Both banks full, dropped write, then hand-off
    for (int i = 0; i < 4; i++) write_word(8'(i), 8'(8'hA0 + i));
    pulse_w();
    for (int i = 0; i < 4; i++) write_word(8'(i), 8'(8'hB0 + i));
    pulse_w();
    check_v("t2_level", {6'b0, level}, 8'd2);
    check_b("t2_w_ready", w_ready, 1'b0);
    write_word(8'd0, 8'hFF);
    tick();
    rd("t2_q_a0", 8'd0, 8'hA0);
    pulse_r();
    rd("t2_q_b0", 8'd0, 8'hB0);
    check_b("t2_w_ready_after", w_ready, 1'b1);

    // Simultaneous w_done and r_done
    for (int i = 0; i < 4; i++) write_word(8'(i), 8'(8'hC0 + i));
    w_done = 1'b1; r_done = 1'b1;
    tick();
    w_done = 1'b0; r_done = 1'b0;
    check_v("t3_level", {6'b0, level}, 8'd1);
    rd("t3_q_c0", 8'd0, 8'hC0);

    // Out-of-range write and read
    write_word(8'd5, 8'h55);
    rd("t4_q_oob", 8'd5, 8'h00);
    pulse_w();
    pulse_r();
    rd("t4_no_alias", 8'd1, 8'hB1);

    // Ignored handshakes
    pulse_r();
    pulse_r();
    check_b("t5_r_valid", r_valid, 1'b0);
    check_v("t5_level0", {6'b0, level}, 8'd0);
    w_done = 1'b1;
    tick();
    tick();
    w_done = 1'b0;
    check_v("t5_level2", {6'b0, level}, 8'd2);
    check_b("t5_w_ready", w_ready, 1'b0);
    pulse_w();
    check_v("t5_level2_hold", {6'b0, level}, 8'd2);

    // Reset with a write in flight
    pulse_r();
    we = 1'b1; wa = 8'd2; d = 8'h99;
    tick();
    we = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_v("t6_level", {6'b0, level}, 8'd0);
    count_busy(CLR ? 4 : 0);
    pulse_w();
    pulse_w();
    pulse_r();
    rd("t6_q_kept", 8'd2, CLR ? 8'h00 : 8'hC2);

`ifdef PINGPONG_CLEAR_EN
    for (int i = 0; i < 4; i++) write_word(8'(i), 8'h5A);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_b("t7_mid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(4);
    pulse_w();
    pulse_w();
    for (int i = 0; i < 4; i++) rd("t7_bank0_zero", 8'(i), 8'h00);
    pulse_r();
    for (int i = 0; i < 4; i++) rd("t7_bank1_zero", 8'(i), 8'h00);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
